// File: rtl/avmm_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM burst read engine between N_REQ fetch clients.
// Each client gets a single pending slot; only one burst is outstanding at the reader.
module avmm_read_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned SDRAM_W = 128,
  localparam int unsigned GidW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_start,
  input  logic [N_REQ*32-1:0] req_addr,
  input  logic [N_REQ*11-1:0] req_cnt,
  output logic [N_REQ-1:0]    req_drop,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [10:0]         rsp_idx,
  output logic [SDRAM_W-1:0]  rsp_data,
  output logic [31:0]         read_addr,
  output logic [10:0]         read_cnt,
  output logic                read_start,
  input  logic                out_valid,
  input  logic [10:0]         out_idx,
  input  logic [SDRAM_W-1:0]  out_data,
  output logic                busy,
  output logic [GidW-1:0]     grant_id
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   pend_q, pend_d;
  logic [31:0]        pend_addr_q [N_REQ];
  logic [31:0]        pend_addr_d [N_REQ];
  logic [10:0]        pend_cnt_q  [N_REQ];
  logic [10:0]        pend_cnt_d  [N_REQ];
  logic [GidW-1:0]    rr_q, rr_d;
  logic [GidW-1:0]    grant_d;
  logic [31:0]        read_addr_d;
  logic [10:0]        read_cnt_d;
  logic [N_REQ-1:0]   drop_d;
  logic               found;
  logic [GidW-1:0]    pick;
  int unsigned        scan_idx;
  logic               last_beat;

  // First pending slot at or after the RR pointer, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (32'(rr_q) + 32'(k)) % N_REQ;
      if (!found && pend_q[scan_idx[GidW-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[GidW-1:0];
      end
    end
  end

  assign last_beat = out_valid && (out_idx == read_cnt - 11'd1);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_cnt_d  = pend_cnt_q;
    rr_d        = rr_q;
    grant_d     = grant_id;
    read_addr_d = read_addr;
    read_cnt_d  = read_cnt;
    drop_d      = '0;

    // Accepts only target clear slots; grants only clear set slots, so they never collide.
    for (int i = 0; i < N_REQ; i++) begin
      if (req_start[i]) begin
        if (pend_q[i] || req_cnt[i*11 +: 11] == 11'd0) begin
          drop_d[i] = 1'b1;
        end else begin
          pend_d[i]      = 1'b1;
          pend_addr_d[i] = req_addr[i*32 +: 32];
          pend_cnt_d[i]  = req_cnt[i*11 +: 11];
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d      = pick;
          read_addr_d  = pend_addr_q[pick];
          read_cnt_d   = pend_cnt_q[pick];
          pend_d[pick] = 1'b0;
          state_d      = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (last_beat) begin
          state_d = StIdle;
          rr_d    = (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + GidW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      rr_q       <= '0;
      grant_id   <= '0;
      read_addr  <= '0;
      read_cnt   <= '0;
      read_start <= 1'b0;
      req_drop   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        pend_addr_q[i] <= '0;
        pend_cnt_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rr_q        <= rr_d;
      grant_id    <= grant_d;
      read_addr   <= read_addr_d;
      read_cnt    <= read_cnt_d;
      read_start  <= (state_d == StIssue);
      req_drop    <= drop_d;
      pend_addr_q <= pend_addr_d;
      pend_cnt_q  <= pend_cnt_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = out_valid && (state_q == StWait) && (grant_id == GidW'(i));
    end
  end

  assign rsp_idx  = out_idx;
  assign rsp_data = out_data;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_avmm_read_arbiter.sv
// Self-checking bench for avmm_read_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_avmm_read_arbiter;

  localparam int N = 4;
  localparam int W = 128;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_start = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N*11-1:0] req_cnt = '0;
  logic [N-1:0]    req_drop, rsp_valid;
  logic [10:0]     rsp_idx;
  logic [W-1:0]    rsp_data;
  logic [31:0]     read_addr;
  logic [10:0]     read_cnt;
  logic            read_start;
  logic            out_valid = 1'b0;
  logic [10:0]     out_idx = '0;
  logic [W-1:0]    out_data = '0;
  logic            busy;
  logic [1:0]      grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  avmm_read_arbiter #(.N_REQ(N), .SDRAM_W(W)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_addr(req_addr), .req_cnt(req_cnt),
    .req_drop(req_drop), .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
    .read_addr(read_addr), .read_cnt(read_cnt), .read_start(read_start),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input int c);
    req_start[i]         = 1'b1;
    req_addr[i*32 +: 32] = a;
    req_cnt[i*11 +: 11]  = 11'(c);
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_start = '0;
    out_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits for a burst start, records who was granted, then returns nbeats beats.
  task automatic serve(input int nbeats, output int gid, output logic [31:0] addr,
                       output bit ok);
    ok   = 1'b0;
    gid  = -1;
    addr = '0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (read_start === 1'b1) begin
        gid  = int'(grant_id);
        addr = read_addr;
        ok   = 1'b1;
      end
      cyc();
    end
    if (ok) begin
      for (int b = 0; b < nbeats; b++) begin
        out_valid = 1'b1;
        out_idx   = 11'(b);
        out_data  = {$urandom, $urandom, $urandom, $urandom};
        cyc();
      end
      out_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (read_start !== 1'b0) begin n_bad++; $display("FAIL reset_read_start: got %b want 0", read_start); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    n_cmp++; if (read_addr !== 32'd0) begin n_bad++; $display("FAIL reset_read_addr: got %h want 0", read_addr); end
    n_cmp++; if (read_cnt !== 11'd0) begin n_bad++; $display("FAIL reset_read_cnt: got %0d want 0", read_cnt); end
    n_cmp++; if (req_drop !== 4'b0) begin n_bad++; $display("FAIL reset_req_drop: got %b want 0", req_drop); end
    n_cmp++; if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    reset_dut();
    set_req(1, 32'h1000, 2);
    cyc();
    req_start = '0;
    @(negedge clk);
    n_cmp++; if ({read_start, busy} !== 2'b00) begin n_bad++; $display("FAIL single_c1: got rs/busy %b want 00", {read_start, busy}); end
    cyc();
    @(negedge clk);
    n_cmp++; if (read_start !== 1'b1) begin n_bad++; $display("FAIL single_start: got %b want 1", read_start); end
    n_cmp++; if (read_addr !== 32'h1000) begin n_bad++; $display("FAIL single_addr: got %h want 1000", read_addr); end
    n_cmp++; if (read_cnt !== 11'd2) begin n_bad++; $display("FAIL single_cnt: got %0d want 2", read_cnt); end
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL single_gid: got %0d want 1", grant_id); end
    for (int b = 0; b < 2; b++) begin
      cyc();
      d = {$urandom, $urandom, $urandom, $urandom};
      out_valid = 1'b1; out_idx = 11'(b); out_data = d;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL single_rsp_valid%0d: got %b want 0010", b, rsp_valid); end
      n_cmp++; if (rsp_data !== d || rsp_idx !== 11'(b)) begin n_bad++; $display("FAIL single_rsp_beat%0d: got idx %0d data %h want idx %0d data %h", b, rsp_idx, rsp_data, b, d); end
    end
    cyc();
    out_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    int g; logic [31:0] a; bit ok;
    int order2 [2] = '{0, 3};
    reset_dut();
    for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), 1);
    cyc();
    req_start = '0;
    for (int i = 0; i < N; i++) begin
      serve(1, g, a, ok);
      n_cmp++; if (!ok || g != i || a !== 32'(32'h100 * (i + 1))) begin n_bad++; $display("FAIL simul_grant%0d: got ok %0d id %0d addr %h want id %0d addr %h", i, ok, g, a, i, 32'h100 * (i + 1)); end
    end
    set_req(0, 32'h700, 1);
    set_req(3, 32'h730, 1);
    cyc();
    req_start = '0;
    for (int k = 0; k < 2; k++) begin
      serve(1, g, a, ok);
      n_cmp++; if (!ok || g != order2[k]) begin n_bad++; $display("FAIL simul_wrap%0d: got ok %0d id %0d want id %0d", k, ok, g, order2[k]); end
    end
  endtask

  task automatic test_fairness();
    int g; logic [31:0] a; bit ok;
    reset_dut();
    set_req(0, 32'hA000, 2);
    cyc();
    req_start = '0;
    cyc();
    set_req(0, 32'hB000, 1);
    set_req(2, 32'hC000, 1);
    @(negedge clk);
    n_cmp++; if (read_start !== 1'b1 || grant_id !== 2'd0) begin n_bad++; $display("FAIL fair_first: got rs %b id %0d want rs 1 id 0", read_start, grant_id); end
    cyc();
    req_start = '0;
    out_valid = 1'b1; out_idx = 11'd0;
    @(negedge clk);
    n_cmp++; if (req_drop !== 4'b0 || rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL fair_rerequest: got drop %b rv %b want drop 0000 rv 0001", req_drop, rsp_valid); end
    cyc();
    out_idx = 11'd1;
    cyc();
    out_valid = 1'b0;
    serve(1, g, a, ok);
    n_cmp++; if (!ok || g != 2 || a !== 32'hC000) begin n_bad++; $display("FAIL fair_second: got ok %0d id %0d addr %h want id 2 addr c000", ok, g, a); end
    serve(1, g, a, ok);
    n_cmp++; if (!ok || g != 0 || a !== 32'hB000) begin n_bad++; $display("FAIL fair_third: got ok %0d id %0d addr %h want id 0 addr b000", ok, g, a); end
  endtask

  task automatic test_drop();
    int g; logic [31:0] a; bit ok; bit seen;
    reset_dut();
    set_req(0, 32'h0, 3);
    cyc();
    req_start = '0;
    cyc();
    set_req(2, 32'h2000, 1);
    cyc();
    req_start = '0;
    set_req(2, 32'h2222, 1);
    set_req(3, 32'h3000, 0);
    out_valid = 1'b1; out_idx = 11'd0;
    @(negedge clk);
    n_cmp++; if (req_drop !== 4'b0000) begin n_bad++; $display("FAIL drop_early: got %b want 0000", req_drop); end
    cyc();
    req_start = '0;
    out_idx = 11'd1;
    @(negedge clk);
    n_cmp++; if (req_drop !== 4'b1100) begin n_bad++; $display("FAIL drop_pulse: got %b want 1100", req_drop); end
    cyc();
    out_idx = 11'd2;
    @(negedge clk);
    n_cmp++; if (req_drop !== 4'b0000) begin n_bad++; $display("FAIL drop_once: got %b want 0000", req_drop); end
    cyc();
    out_valid = 1'b0;
    serve(1, g, a, ok);
    n_cmp++; if (!ok || g != 2 || a !== 32'h2000) begin n_bad++; $display("FAIL drop_first_addr: got ok %0d id %0d addr %h want id 2 addr 2000", ok, g, a); end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= read_start; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL drop_no_burst: got extra start %b want 0", seen); end
  endtask

  task automatic test_stray();
    reset_dut();
    cyc();
    out_valid = 1'b1; out_idx = 11'd0; out_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stray0: got rv %b busy %b want 0000/0", rsp_valid, busy); end
    cyc();
    out_idx = 11'd5;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0 || busy !== 1'b0 || read_start !== 1'b0) begin n_bad++; $display("FAIL stray1: got rv %b busy %b rs %b want 0000/0/0", rsp_valid, busy, read_start); end
    cyc();
    out_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int g; logic [31:0] a; bit ok; bit seen;
    reset_dut();
    set_req(1, 32'h4000, 4);
    cyc();
    req_start = '0;
    cyc();
    cyc();
    out_valid = 1'b1; out_idx = 11'd0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL rmid_beat0: got %b want 0010", rsp_valid); end
    cyc();
    rst = 1'b1;
    out_idx = 11'd1;
    @(negedge clk);
    n_cmp++; if ({rsp_valid, busy, read_start, grant_id} !== 8'b0) begin n_bad++; $display("FAIL rmid_flags: got rv/busy/rs/gid %b want 0", {rsp_valid, busy, read_start, grant_id}); end
    n_cmp++; if (read_addr !== 32'd0 || read_cnt !== 11'd0) begin n_bad++; $display("FAIL rmid_regs: got addr %h cnt %0d want 0/0", read_addr, read_cnt); end
    for (int b = 2; b < 4; b++) begin
      cyc();
      rst = 1'b0;
      out_idx = 11'(b);
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL rmid_late%0d: got %b want 0000", b, rsp_valid); end
    end
    cyc();
    out_valid = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= read_start; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rmid_no_pending: got start %b want 0", seen); end
    cyc();
    set_req(2, 32'h5000, 1);
    cyc();
    req_start = '0;
    serve(1, g, a, ok);
    n_cmp++; if (!ok || g != 2 || a !== 32'h5000) begin n_bad++; $display("FAIL rmid_after: got ok %0d id %0d addr %h want id 2 addr 5000", ok, g, a); end
  endtask

  // Model: per-client slots plus an abstract "who owns the reader" phase.
  task automatic test_random();
    bit          m_pend [N];
    logic [31:0] m_paddr [N];
    int          m_pcnt [N];
    bit          old_pend [N];
    int          m_phase = 0;  // 0 free, 1 start pulse, 2 beats returning
    int          m_gid = 0, m_rr = 0, m_rcnt = 0, m_beat = 0;
    logic [31:0] m_raddr = '0;
    logic [N-1:0] m_drop = '0;
    logic [54:0] got, exp;
    logic [N-1:0] exp_rv;
    bit found;
    int c, j;
    reset_dut();
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_paddr[i] = '0; m_pcnt[i] = 0; end
    for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
      for (int i = 0; i < N; i++) begin
        req_start[i] = ($urandom_range(0, 7) == 0);
        req_addr[i*32 +: 32] = $urandom;
        req_cnt[i*11 +: 11] = 11'($urandom_range(0, 4));
      end
      out_data = {$urandom, $urandom, $urandom, $urandom};
      if (m_phase == 2 && $urandom_range(0, 3) != 0) begin
        out_valid = 1'b1; out_idx = 11'(m_beat); m_beat++;
      end else if (m_phase != 2 && $urandom_range(0, 9) == 0) begin
        out_valid = 1'b1; out_idx = 11'($urandom_range(0, 7));
      end else begin
        out_valid = 1'b0;
      end
      @(negedge clk);
      exp_rv = (out_valid && m_phase == 2) ? 4'(1 << m_gid) : 4'b0;
      exp = {m_phase == 1, m_phase != 0, 2'(m_gid), m_raddr, 11'(m_rcnt), m_drop, exp_rv};
      got = {read_start, busy, grant_id, read_addr, read_cnt, req_drop, rsp_valid};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rand_ctrl@%0d: got %h want %h", cyc_n, got, exp); end
      n_cmp++; if (rsp_idx !== out_idx || rsp_data !== out_data) begin n_bad++; $display("FAIL rand_passthru@%0d: got idx %0d data %h want idx %0d data %h", cyc_n, rsp_idx, rsp_data, out_idx, out_data); end
      old_pend = m_pend;
      case (m_phase)
        0: begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (!found && old_pend[j]) begin
              found = 1; m_gid = j; m_raddr = m_paddr[j]; m_rcnt = m_pcnt[j];
              m_pend[j] = 0; m_phase = 1;
            end
          end
        end
        1: begin m_phase = 2; m_beat = 0; end
        default: begin
          if (out_valid && int'(out_idx) == m_rcnt - 1) begin
            m_phase = 0; m_rr = (m_gid + 1) % N;
          end
        end
      endcase
      m_drop = '0;
      for (int i = 0; i < N; i++) begin
        if (req_start[i]) begin
          c = int'(req_cnt[i*11 +: 11]);
          if (old_pend[i] || c == 0) m_drop[i] = 1'b1;
          else begin m_pend[i] = 1; m_paddr[i] = req_addr[i*32 +: 32]; m_pcnt[i] = c; end
        end
      end
      cyc();
    end
    req_start = '0;
    out_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_drop();
    test_stray();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avmm_read_arbiter.md
Name: avmm_read_arbiter

Overview:
- Shares the single Avalon-MM burst read engine (read_addr/read_cnt/read_start out; out_valid/out_idx/out_data back) between N_REQ fetch clients: param fetcher, activation fetcher, instruction fetcher.
- Latches each client's one-cycle start pulse and grants bursts round-robin.
- Allows only one burst outstanding at the reader at any time.
- Routes returning beats to the granted client only.

Parameters:
N_REQ, 4, number of requesting clients (2..8)
SDRAM_W, 128, Avalon read data width in bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_start  in  N_REQ  per-client one-cycle burst request pulse
req_addr  in  N_REQ*32  per-client byte base address; client i at [i*32 +: 32]; sampled with req_start[i]
req_cnt  in  N_REQ*11  per-client burst beat count; client i at [i*11 +: 11]; sampled with req_start[i]
req_drop  out  N_REQ  one-cycle pulse: request from client i discarded
rsp_valid  out  N_REQ  per-client beat valid
rsp_idx  out  11  beat index, broadcast to all clients
rsp_data  out  SDRAM_W  beat data, broadcast to all clients
read_addr  out  32  to reader: burst base address
read_cnt  out  11  to reader: burst count
read_start  out  1  to reader: one-cycle start pulse
out_valid  in  1  from reader: beat valid
out_idx  in  11  from reader: beat index, 0..cnt-1
out_data  in  SDRAM_W  from reader: beat data
busy  out  1  high in ISSUE or WAIT
grant_id  out  clog2(N_REQ)  index of current/last granted client

Behaviour:
- Reset values: read_addr=0, read_cnt=0, read_start=0, grant_id=0, busy=0, req_drop=0, all pending flags=0, RR pointer=0, state=IDLE.
- Reset asserted mid-burst aborts immediately. Beats still returning from the reader after reset are not forwarded: rsp_valid stays 0 because state≠WAIT.
- Pending slot per client (flag, addr, cnt):
  - req_start[i] with flag clear and req_cnt≠0: set flag and capture addr/cnt on the next edge.
  - req_start[i] with flag set: request ignored, req_drop[i] pulses one cycle later.
  - req_start[i] with req_cnt=0: request ignored, req_drop[i] pulses one cycle later.
  - A flag clears on the grant edge. The granted client may therefore re-request during its own burst; that request pends normally.
- State machine:
  - IDLE: if any flag is set, pick the first set flag at or after the RR pointer, wrapping modulo N_REQ. On that edge: load read_addr/read_cnt from the slot, set grant_id, clear the flag, go to ISSUE. Same-cycle requests from several clients are resolved by this pointer scan.
  - ISSUE: read_start=1 for exactly this one cycle; go to WAIT.
  - WAIT: when out_valid && out_idx==read_cnt-1, go to IDLE and set RR pointer = grant_id+1 mod N_REQ.
- read_start is registered and is high only in ISSUE. read_addr/read_cnt hold their value until the next grant.
- Latency: req_start at edge t → flag set at t+1 → IDLE grant at t+1 → read_start high during cycle t+2 (idle arbiter). Back-to-back bursts have one IDLE cycle between the last beat and the next grant.
- Response routing is combinational:
  - rsp_valid[i] = out_valid && state==WAIT && grant_id==i.
  - rsp_idx = out_idx; rsp_data = out_data, passed through unchanged.
- out_valid seen in IDLE or ISSUE is ignored and not forwarded.
- busy = (state!=IDLE).

Test Plan:
1. Single client: req_start[1] with addr=0x1000, cnt=2 at cycle 0 → read_start high at cycle 2 with read_addr=0x1000, read_cnt=2; beats idx 0,1 → rsp_valid[1] high for both, rsp_valid[0,2,3]=0; busy falls after idx 1.
2. Simultaneous: req_start=4'b1111 with cnt=1 each, pointer=0 → grants in order 0,1,2,3. Next round with clients 0 and 3 requesting → client 0 granted first (pointer wrapped to 0).
3. Fairness: client 0 re-requests during its own burst while client 2 pends → client 2 granted before client 0's second burst.
4. Drop: req_start[2] twice before grant → req_drop[2] pulses once, only the first addr issued. req_cnt=0 on client 3 → req_drop[3] pulses, no burst.
5. Stray beat: out_valid in IDLE → all rsp_valid stay 0, state unchanged.
6. Reset mid-WAIT after idx 0 of a cnt=4 burst → all outputs at reset values, pending flags clear, remaining beats not forwarded, next request serviced normally.
